ring_rr_arbiter: RTL and testbench
==================================

Name: ring_rr_arbiter

Overview:
- Round-robin arbiter that shares one resource among N requesters.
- Priority is tracked by a one-hot ring pointer that rotates like the team's 4-bit ring counter.
- The granted requester holds the resource until it drops its request or a hold limit expires; the pointer then rotates past the winner.
- Sits between requesting blocks and a shared datapath (bus, counter, memory port) and sequences access to it.

Parameters:
- N, 4, number of requesters; N >= 2.
- MAX_HOLD, 8, maximum consecutive cycles a grant is held; MAX_HOLD >= 1.
- IDW, $clog2(N), width of grant_id.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low; all state clears immediately when rst=0.
- en  input  1  arbitration enable; when low, no new grants are issued.
- req  input  N  request vector; bit i = requester i.
- grant  output  N  registered one-hot grant, or all-zero when idle.
- grant_valid  output  1  high when grant is non-zero.
- grant_id  output  IDW  binary index of the granted requester; 0 when idle.
- ptr  output  N  one-hot priority ring pointer; this bit has highest priority.

Behaviour:
- Async reset (rst=0):
  - grant = 0, grant_valid = 0, grant_id = 0.
  - ptr = 1 (bit0 set), hold_cnt = 0, state = IDLE.
  - Takes effect without a clock edge, including mid-grant.
- State register: two states, IDLE and GRANT.
- Arbitration function arb(req, p):
  - Scans bits circularly, starting at the bit set in p and moving toward higher indices with wrap from N-1 to 0.
  - The first set req bit wins.
  - Result is one-hot, or zero if req = 0.
- IDLE:
  - If en=1 and req != 0: at the next edge, grant <= arb(req, ptr), state <= GRANT, hold_cnt <= 1. This is 1-cycle latency from request sampled to grant visible.
  - Otherwise remain in IDLE, grant = 0.
  - ptr is unchanged while in IDLE.
- GRANT, with g = the granted index:
  - Release condition: req[g] = 0, or hold_cnt == MAX_HOLD.
  - No release: grant holds and hold_cnt increments. A grant therefore lasts at most exactly MAX_HOLD cycles.
  - On release, at the same edge:
    - ptr <= rotate-left-by-1 of grant (bit (g+1) mod N).
    - If en=1 and req != 0: grant <= arb(req, new ptr), hold_cnt <= 1, stay in GRANT. This is a back-to-back handover with no idle cycle.
    - Otherwise grant <= 0 and state <= IDLE.
- Timeout with req[g] still high:
  - g becomes lowest priority under the new ptr.
  - g is re-granted at once only if it is the sole requester; hold_cnt restarts at 1.
- en=0 during GRANT:
  - The current grant runs to its normal release.
  - Then the arbiter goes to IDLE with no re-arbitration.
- Requests from non-granted bits that rise or fall during a grant are ignored until release.
- Outputs:
  - grant_valid = |grant.
  - grant_id = encode(grant), derived from registered state (no combinational path from req).
  - ptr is always exactly one-hot.
- Simultaneous events on the same edge:
  - Release and a new request arriving: the new request is included in arbitration.
  - Release and en falling: go to IDLE.
- hold_cnt is $clog2(MAX_HOLD+1) bits and never exceeds MAX_HOLD.

Test Plan:
1. Reset: hold rst=0 while toggling clk -> grant=0000, grant_valid=0, grant_id=0, ptr=0001. Assert rst=0 mid-grant -> grant=0000 before the next clk edge.
2. Fairness (N=4, MAX_HOLD=4): req=1111 held, en=1 -> grant 0001 for 4 cycles, then 0010 x4, 0100 x4, 1000 x4, then 0001 again. ptr steps 0010, 0100, 1000, 0001 at each handover, with no idle gaps.
3. Sole requester timeout: req=0100 held -> grant=0100 for 4 cycles, ptr becomes 1000, 0100 is re-granted on the same edge; grant_valid stays high continuously.
4. Early release: ptr=0001, req=1010 -> grant=0010. Drop req[1] after 2 grant cycles -> next edge grant=1000, ptr=0100, grant_id=3.
5. Enable gating: en=0, req=1111 -> grant stays 0000 indefinitely. During an active grant of 0001, set en=0 and drop req[0] -> next edge grant=0000, state IDLE, ptr=0010.
6. Late request: grant=0001 (hold_cnt=2), req[2] rises -> no change until release. On release with req=0100 -> grant=0100.

Source files
------------

// File: rtl/ring_rr_arbiter_if.sv
// Request/grant bundle between requesting blocks and the ring round-robin arbiter.
interface ring_rr_arbiter_if #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
);
    logic           en;
    logic [N-1:0]   req;
    logic [N-1:0]   grant;
    logic           grant_valid;
    logic [IDW-1:0] grant_id;
    logic [N-1:0]   ptr;

    modport master (
        output en, req,
        input  grant, grant_valid, grant_id, ptr
    );

    modport slave (
        input  en, req,
        output grant, grant_valid, grant_id, ptr
    );
endinterface

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority pointer and a per-grant hold limit.
module ring_rr_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int IDW      = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    ring_rr_arbiter_if.slave   bus
);
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [N-1:0]   ptr_q, ptr_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic           release_w;

    function automatic logic [IDW-1:0] encode(input logic [N-1:0] v);
        logic [IDW-1:0] id;
        id = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (v[i]) id = id | IDW'(i);
        end
        return id;
    endfunction

    // Circular scan starting at the pointer bit, wrapping from N-1 to 0.
    function automatic logic [N-1:0] arb(input logic [N-1:0] r, input logic [N-1:0] p);
        logic [N-1:0]  res;
        logic          found;
        int unsigned   start;
        int unsigned   idx;
        res   = '0;
        found = 1'b0;
        start = 32'(encode(p));
        for (int unsigned k = 0; k < N; k++) begin
            idx = (start + k) % N;
            if (!found && r[idx]) begin
                res[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return res;
    endfunction

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        release_w = (~|(bus.req & grant_q)) || (hold_q == HW'(MAX_HOLD));
        case (state_q)
            IDLE: begin
                if (bus.en && |bus.req) begin
                    grant_d = arb(bus.req, ptr_q);
                    state_d = GRANT;
                    hold_d  = HW'(1);
                end else begin
                    grant_d = '0;
                end
            end
            GRANT: begin
                if (!release_w) begin
                    hold_d = hold_q + HW'(1);
                end else begin
                    ptr_d = {grant_q[N-2:0], grant_q[N-1]};
                    if (bus.en && |bus.req) begin
                        grant_d = arb(bus.req, ptr_d);
                        hold_d  = HW'(1);
                    end else begin
                        grant_d = '0;
                        hold_d  = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= N'(1);
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = |grant_q;
    assign bus.grant_id    = encode(grant_q);
    assign bus.ptr         = ptr_q;
endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Directed table-driven bench for ring_rr_arbiter (N=4, MAX_HOLD=4).
module tb_ring_rr_arbiter;
    logic clk;
    logic rst;

    ring_rr_arbiter_if #(.N(4), .IDW(2)) ifc ();

    ring_rr_arbiter #(.N(4), .MAX_HOLD(4), .IDW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [3:0] req;
        logic [3:0] grant;
        logic [3:0] ptr;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        case (g)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    task automatic add(input logic en, input logic [3:0] req, input logic [3:0] g, input logic [3:0] p);
        vec_t v;
        v.en = en; v.req = req; v.grant = g; v.ptr = p;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] g, input logic [3:0] p);
        chk({tag, " grant"}, 32'(ifc.grant), 32'(g));
        chk({tag, " valid"}, 32'(ifc.grant_valid), 32'(|g));
        chk({tag, " id"}, 32'(ifc.grant_id), 32'(idx_of(g)));
        chk({tag, " ptr"}, 32'(ifc.ptr), 32'(p));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [3:0] req);
        ifc.en  = en;
        ifc.req = req;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(1'b0, 4'b0000);
        repeat (2) step();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 4'b0000);

        // Fairness: each requester holds for MAX_HOLD cycles, back-to-back handover.
        for (int k = 0; k < 16; k++) begin
            add(1'b1, 4'b1111, 4'b0001 << (k / 4), 4'b0001 << (k / 4));
        end
        add(1'b1, 4'b1111, 4'b0001, 4'b0001);
        // Sole requester: handed over, held for 4, then re-granted on timeout.
        add(1'b1, 4'b0100, 4'b0100, 4'b0010);
        add(1'b1, 4'b0100, 4'b0100, 4'b0010);
        add(1'b1, 4'b0100, 4'b0100, 4'b0010);
        add(1'b1, 4'b0100, 4'b0100, 4'b0010);
        add(1'b1, 4'b0100, 4'b0100, 4'b1000);
        add(1'b1, 4'b0100, 4'b0100, 4'b1000);
        // Release with en low goes idle; en low blocks new grants.
        add(1'b0, 4'b0000, 4'b0000, 4'b1000);
        add(1'b0, 4'b1111, 4'b0000, 4'b1000);
        add(1'b0, 4'b1111, 4'b0000, 4'b1000);
        add(1'b0, 4'b1111, 4'b0000, 4'b1000);

        // Reset held while clock toggles.
        repeat (3) step();
        check_out("reset", 4'b0000, 4'b0001);
        rst = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].req);
            step();
            check_out($sformatf("vec%0d", i), vecs[i].grant, vecs[i].ptr);
        end

        // Async reset mid-grant clears before the next edge.
        do_reset();
        drive(1'b1, 4'b0001);
        step();
        check_out("pre_async", 4'b0001, 4'b0001);
        #3 rst = 1'b0;
        #1 check_out("async_rst", 4'b0000, 4'b0001);
        rst = 1'b1;

        // Early release hands over to next requester.
        do_reset();
        drive(1'b1, 4'b1010);
        step();
        check_out("early1", 4'b0010, 4'b0001);
        step();
        check_out("early2", 4'b0010, 4'b0001);
        drive(1'b1, 4'b1000);
        step();
        check_out("early3", 4'b1000, 4'b0100);

        // en falls together with release.
        do_reset();
        drive(1'b1, 4'b0001);
        step();
        check_out("en_a", 4'b0001, 4'b0001);
        drive(1'b0, 4'b0000);
        step();
        check_out("en_b", 4'b0000, 4'b0010);
        drive(1'b0, 4'b1111);
        step();
        check_out("en_c", 4'b0000, 4'b0010);

        // Late request ignored until release, then included.
        do_reset();
        drive(1'b1, 4'b0001);
        step();
        step();
        check_out("late1", 4'b0001, 4'b0001);
        drive(1'b1, 4'b0101);
        step();
        check_out("late2", 4'b0001, 4'b0001);
        drive(1'b1, 4'b0100);
        step();
        check_out("late3", 4'b0100, 4'b0010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
